// File: rtl/torus_tile_switch_if.sv
// Bundle of the tile switch's configuration, control and data ports.
// The master side drives the requests and inputs; the slave side is the switch.
interface torus_tile_switch_if #(
    parameter int data_width = 16,
    parameter int ctx_aw     = 4
);
    logic                  cfg_we;
    logic [ctx_aw-1:0]     cfg_addr;
    logic [14:0]           cfg_data;
    logic                  start;
    logic                  stop;
    logic [ctx_aw-1:0]     ctx_last;
    logic [7:0]            iter;
    logic [data_width-1:0] sw_in0, sw_in1, sw_in2, sw_in3;
    logic [data_width-1:0] local_in;
    logic [data_width-1:0] sw_out0, sw_out1, sw_out2, sw_out3;
    logic [data_width-1:0] local_out;
    logic                  busy;
    logic                  done;
    logic [ctx_aw-1:0]     ctx_ptr;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop, ctx_last, iter,
               sw_in0, sw_in1, sw_in2, sw_in3, local_in,
        input  sw_out0, sw_out1, sw_out2, sw_out3, local_out, busy, done, ctx_ptr
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop, ctx_last, iter,
               sw_in0, sw_in1, sw_in2, sw_in3, local_in,
        output sw_out0, sw_out1, sw_out2, sw_out3, local_out, busy, done, ctx_ptr
    );
endinterface

// File: rtl/torus_tile_switch.sv
// Context-sequenced crossbar for one torus tile: each RUN cycle the five
// registered outputs take the sources named by the current context word.

module torus_tile_sel #(
    parameter int data_width = 16
) (
    input  logic [2:0]                 sel,
    input  logic [4:0][data_width-1:0] src,
    input  logic [data_width-1:0]      cur,
    output logic [data_width-1:0]      y
);
    always_comb begin
        y = '0;
        case (sel)
            3'd0: y = src[0];
            3'd1: y = src[1];
            3'd2: y = src[2];
            3'd3: y = src[3];
            3'd4: y = src[4];
            3'd5: y = cur;
            default: y = '0;
        endcase
    end
endmodule

module torus_tile_switch #(
    parameter int data_width = 16,
    parameter int ctx_depth  = 16,
    parameter int ctx_aw     = 4
) (
    input logic             clk,
    input logic             rst_n,
    torus_tile_switch_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ctx_aw-1:0] PTR_ONE = ctx_aw'(1);

    state_t state_q, state_d;

    logic [14:0]                 ctx_mem [ctx_depth];
    logic [14:0]                 ctx_word;
    logic [ctx_aw-1:0]           ctx_ptr_q, ctx_ptr_d;
    logic [ctx_aw-1:0]           ctx_last_q, ctx_last_d;
    logic [7:0]                  iter_q, iter_d;
    logic [7:0]                  pass_q, pass_d;
    logic                        done_q, done_d;
    logic [4:0][data_width-1:0]  out_q, out_d, sel_val;
    logic [4:0][data_width-1:0]  src;
    logic                        launch, wrap, last_pass, busy;

    assign src       = {bus.local_in, bus.sw_in3, bus.sw_in2, bus.sw_in1, bus.sw_in0};
    assign ctx_word  = ctx_mem[ctx_ptr_q];
    assign launch    = bus.start && !bus.stop;
    assign wrap      = (ctx_ptr_q == ctx_last_q);
    assign last_pass = (iter_q != 8'd0) && ((pass_q + 8'd1) == iter_q);

    // Output lanes 0-3 are the neighbours, lane 4 the local PE.
    for (genvar g = 0; g < 5; g++) begin : g_lane
        torus_tile_sel #(.data_width(data_width)) u_sel (
            .sel (ctx_word[3*g +: 3]),
            .src (src),
            .cur (out_q[g]),
            .y   (sel_val[g])
        );
    end

    // Context memory is configuration state and survives reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state_q == IDLE)
            ctx_mem[bus.cfg_addr] <= bus.cfg_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = RUN;
            RUN:  if (bus.stop || (wrap && last_pass)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_comb begin
        ctx_ptr_d  = ctx_ptr_q;
        ctx_last_d = ctx_last_q;
        iter_d     = iter_q;
        pass_d     = pass_q;
        out_d      = out_q;
        done_d     = 1'b0;
        if (state_q == IDLE && launch) begin
            ctx_ptr_d  = '0;
            pass_d     = '0;
            ctx_last_d = bus.ctx_last;
            iter_d     = bus.iter;
        end else if (state_q == RUN && !bus.stop) begin
            out_d = sel_val;
            if (wrap) begin
                ctx_ptr_d = '0;
                pass_d    = pass_q + 8'd1;
                done_d    = last_pass;
            end else begin
                ctx_ptr_d = ctx_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctx_ptr_q  <= '0;
            ctx_last_q <= '0;
            iter_q     <= '0;
            pass_q     <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            ctx_ptr_q  <= ctx_ptr_d;
            ctx_last_q <= ctx_last_d;
            iter_q     <= iter_d;
            pass_q     <= pass_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

    assign bus.sw_out0   = out_q[0];
    assign bus.sw_out1   = out_q[1];
    assign bus.sw_out2   = out_q[2];
    assign bus.sw_out3   = out_q[3];
    assign bus.local_out = out_q[4];
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.ctx_ptr   = ctx_ptr_q;
endmodule

// File: tb/tb_torus_tile_switch.sv
// Directed checks of the tile switch: single pass, rotation, hold, stop,
// config lockout during a run and mid-run reset.
module tb_torus_tile_switch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    torus_tile_switch_if #(.data_width(16), .ctx_aw(4)) bus ();

    torus_tile_switch #(.data_width(16), .ctx_depth(16), .ctx_aw(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [14:0] ALL4 = {3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    localparam logic [14:0] ALL5 = {3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    localparam logic [14:0] ALL6 = {3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
    localparam logic [14:0] ROT  = {3'd4, 3'd0, 3'd3, 3'd2, 3'd1};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] el);
        chk({tag, ".out0"}, 32'(bus.sw_out0), 32'(e0));
        chk({tag, ".out1"}, 32'(bus.sw_out1), 32'(e1));
        chk({tag, ".out2"}, 32'(bus.sw_out2), 32'(e2));
        chk({tag, ".out3"}, 32'(bus.sw_out3), 32'(e3));
        chk({tag, ".local"}, 32'(bus.local_out), 32'(el));
    endtask

    task automatic wr_ctx(input logic [3:0] a, input logic [14:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        cyc();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic go(input logic [3:0] last, input logic [7:0] it);
        bus.ctx_last = last;
        bus.iter     = it;
        bus.start    = 1'b1;
        cyc();
        bus.start    = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
        bus.start = 0; bus.stop = 0; bus.ctx_last = 0; bus.iter = 0;
        bus.sw_in0 = 0; bus.sw_in1 = 0; bus.sw_in2 = 0; bus.sw_in3 = 0; bus.local_in = 0;

        // reset state
        cyc(); cyc();
        chk_outs("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.ptr", 32'(bus.ctx_ptr), 32'd0);
        rst_n = 1'b1;

        // single context, single pass, all outputs from local
        wr_ctx(4'd0, ALL4);
        bus.local_in = 16'h00A5;
        go(4'd0, 8'd1);
        chk("p1.busy", 32'(bus.busy), 32'd1);
        chk("p1.ptr", 32'(bus.ctx_ptr), 32'd0);
        chk("p1.pre", 32'(bus.local_out), 32'h0);
        cyc();
        chk_outs("p1", 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);
        chk("p1.busy_end", 32'(bus.busy), 32'd0);
        chk("p1.done", 32'(bus.done), 32'd1);
        cyc();
        chk("p1.done_clr", 32'(bus.done), 32'd0);
        chk("p1.hold", 32'(bus.sw_out2), 32'h00A5);

        // rotate / zero alternation, three passes of two contexts
        wr_ctx(4'd0, ROT);
        wr_ctx(4'd1, ALL6);
        bus.sw_in0 = 16'h1111; bus.sw_in1 = 16'h2222;
        bus.sw_in2 = 16'h3333; bus.sw_in3 = 16'h4444; bus.local_in = 16'h5555;
        go(4'd1, 8'd3);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rot%0d.ptr", k), 32'(bus.ctx_ptr), 32'(k % 2));
            chk($sformatf("rot%0d.busy", k), 32'(bus.busy), 32'd1);
            chk($sformatf("rot%0d.done_pre", k), 32'(bus.done), 32'd0);
            cyc();
            if (k % 2 == 0)
                chk_outs($sformatf("rot%0d", k), 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h5555);
            else
                chk_outs($sformatf("rot%0d", k), 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        end
        chk("rot.done", 32'(bus.done), 32'd1);
        chk("rot.busy_end", 32'(bus.busy), 32'd0);
        cyc();
        chk("rot.done_clr", 32'(bus.done), 32'd0);

        // hold code keeps the prior value while inputs move every cycle
        wr_ctx(4'd0, ALL4);
        wr_ctx(4'd1, ALL5);
        go(4'd1, 8'd2);
        for (int k = 0; k < 4; k++) begin
            bus.local_in = 16'h1000 + 16'(k);
            bus.sw_in0 = 16'h2000 + 16'(k); bus.sw_in1 = 16'h2100 + 16'(k);
            bus.sw_in2 = 16'h2200 + 16'(k); bus.sw_in3 = 16'h2300 + 16'(k);
            cyc();
            v = (k % 2 == 0) ? 16'h1000 + 16'(k) : 16'h1000 + 16'(k - 1);
            chk_outs($sformatf("hold%0d", k), v, v, v, v, v);
        end
        chk("hold.done", 32'(bus.done), 32'd1);

        // start+stop together and stop alone in IDLE do nothing
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc();
        chk("ss.busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        cyc();
        chk("stopidle.busy", 32'(bus.busy), 32'd0);
        bus.stop = 1'b0;

        // context write during RUN is dropped
        bus.local_in = 16'h0A0A;
        go(4'd0, 8'd2);
        wr_ctx(4'd0, ALL6);
        cyc();
        chk("cfgrun.local", 32'(bus.local_out), 32'h0A0A);
        chk("cfgrun.done", 32'(bus.done), 32'd1);
        bus.local_in = 16'h0B0B;
        go(4'd0, 8'd1);
        cyc();
        chk_outs("cfgrun2", 16'h0B0B, 16'h0B0B, 16'h0B0B, 16'h0B0B, 16'h0B0B);

        // free-running with iter=0, stopped after ten RUN cycles
        wr_ctx(4'd1, ALL4);
        wr_ctx(4'd2, ALL4);
        wr_ctx(4'd3, ALL4);
        go(4'd3, 8'd0);
        for (int k = 0; k < 10; k++) begin
            bus.local_in = 16'h3000 + 16'(k);
            cyc();
            chk($sformatf("free%0d.ptr", k), 32'(bus.ctx_ptr), 32'((k + 1) % 4));
            chk($sformatf("free%0d.done", k), 32'(bus.done), 32'd0);
        end
        chk("free.busy", 32'(bus.busy), 32'd1);
        bus.stop = 1'b1; bus.local_in = 16'h7777;
        cyc();
        bus.stop = 1'b0;
        chk("stop.busy", 32'(bus.busy), 32'd0);
        chk("stop.ptr", 32'(bus.ctx_ptr), 32'd2);
        chk("stop.done", 32'(bus.done), 32'd0);
        chk_outs("stop", 16'h3009, 16'h3009, 16'h3009, 16'h3009, 16'h3009);
        cyc();
        chk("stop.done2", 32'(bus.done), 32'd0);
        chk("stop.frozen", 32'(bus.local_out), 32'h3009);

        // reset mid-run, then a clean single pass from the retained ctx0
        bus.local_in = 16'h1234;
        go(4'd0, 8'd0);
        cyc();
        chk("mid.local", 32'(bus.local_out), 32'h1234);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_outs("mrst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("mrst.busy", 32'(bus.busy), 32'd0);
        chk("mrst.done", 32'(bus.done), 32'd0);
        chk("mrst.ptr", 32'(bus.ctx_ptr), 32'd0);
        bus.local_in = 16'h00A5;
        go(4'd0, 8'd1);
        chk("re.busy", 32'(bus.busy), 32'd1);
        cyc();
        chk_outs("re", 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);
        chk("re.done", 32'(bus.done), 32'd1);
        chk("re.busy_end", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
